// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - iterative slice-serial binary/packed-BCD add/subtract unit
module addsub_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic             dec,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [7:0]       flags
);

   localparam int STEPS  = WIDTH / SLICE;
   localparam int DIGITS = SLICE / 4;
   localparam int IW     = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_r, b_r, acc, word;
   logic             sub_r, dec_r, carry;
   logic [IW-1:0]    idx;
   logic [SLICE-1:0] a_k, b_k, s_k;
   logic [SLICE:0]   bsum;
   logic [4:0]       t;
   logic [3:0]       dig;
   logic             c, c_out, v_k, accept, last;

   // Slice arithmetic: binary sum for V, nibble chain for the (optionally BCD-corrected) digits
   always_comb begin
      a_k   = a_r[int'(idx)*SLICE +: SLICE];
      b_k   = sub_r ? ~b_r[int'(idx)*SLICE +: SLICE] : b_r[int'(idx)*SLICE +: SLICE];
      bsum  = {1'b0, a_k} + {1'b0, b_k} + {{SLICE{1'b0}}, carry};
      // V is carry-in XOR carry-out of the slice MSB, always from the uncorrected sum
      v_k   = bsum[SLICE] ^ (a_k[SLICE-1] ^ b_k[SLICE-1] ^ bsum[SLICE-1]);
      c     = carry;
      s_k   = '0;
      t     = '0;
      dig   = '0;
      for (int n = 0; n < DIGITS; n++) begin
         t   = {1'b0, a_k[4*n +: 4]} + {1'b0, b_k[4*n +: 4]} + {4'b0000, c};
         dig = t[3:0];
         if (!dec_r) begin
            c = t[4];
         end else if (!sub_r) begin
            if (t > 5'd9) begin
               dig = t[3:0] + 4'd6;
               c   = 1'b1;
            end else begin
               c   = 1'b0;
            end
         end else begin
            if (!t[4]) begin
               dig = t[3:0] - 4'd6;
               c   = 1'b0;
            end else begin
               c   = 1'b1;
            end
         end
         s_k[4*n +: 4] = dig;
      end
      c_out = c;
   end

   // Full word with the current slice merged in, so the last step can publish it directly
   always_comb begin
      word = acc;
      word[int'(idx)*SLICE +: SLICE] = s_k;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = (idx == IW'(STEPS - 1));
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      busy = (state == RUN);
      done = (state == DONE);
   end

   // State, operand latches, slice accumulation and completion capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         sub_r  <= 1'b0;
         dec_r  <= 1'b0;
         carry  <= 1'b0;
         acc    <= '0;
         result <= '0;
         flags  <= 8'h00;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            dec_r <= dec;
            carry <= cin;
            idx   <= '0;
            acc   <= '0;
         end else if (state == RUN) begin
            acc   <= word;
            carry <= c_out;
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
               result <= word;
               flags  <= {word[WIDTH-1], v_k, 4'b0000, (word == '0), c_out};
            end
         end
      end
   end

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - scoreboard testbench for addsub_seq
module tb_addsub_seq;

   logic        clk = 1'b0;
   logic        reset, start, sub, dec, cin;
   logic [15:0] a, b;
   logic        busy, done;
   logic [15:0] result;
   logic [7:0]  flags;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] r;
      logic [7:0]  f;
   } exp_t;

   exp_t sb[$];

   addsub_seq #(.WIDTH(16), .SLICE(4)) dut (
      .clk(clk), .reset(reset), .start(start), .sub(sub), .dec(dec),
      .a(a), .b(b), .cin(cin), .busy(busy), .done(done),
      .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   // Drive one start cycle from a negedge; returns at the next negedge with inputs scrambled
   task automatic drive_start(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                              input logic idec, input logic icin, input bit track,
                              input logic [15:0] er, input logic [7:0] ef);
      exp_t e;
      a = ia; b = ib; sub = isub; dec = idec; cin = icin; start = 1'b1;
      if (track) begin
         e.r = er;
         e.f = ef;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      sub = 1'($urandom); dec = 1'($urandom); cin = 1'($urandom);
   endtask

   // Wait for done, counting cycles since the accepting edge and cycles without busy
   task automatic wait_done(input int cyc0, output int cyc, output int gaps);
      cyc  = cyc0;
      gaps = 0;
      while (done !== 1'b1 && cyc < 30) begin
         if (busy !== 1'b1) gaps++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; sub = 1'b0; dec = 1'b0; cin = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++; $display("FAIL reset_handshake: busy/done=%b expected 00", {busy, done});
      end
      checks++;
      if (result !== 16'h0000 || flags !== 8'h00) begin
         failures++; $display("FAIL reset_regs: result=%h flags=%h expected 0000/00", result, flags);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_arith;
      logic [15:0] ta[8], tb_[8], tr[8];
      logic [7:0]  tf[8];
      logic [2:0]  tm[8];
      int cyc, gaps;
      exp_t e;
      // {sub, dec, cin}
      ta[0] = 16'h7FFF; tb_[0] = 16'h0001; tm[0] = 3'b000; tr[0] = 16'h8000; tf[0] = 8'hC0;
      ta[1] = 16'h0000; tb_[1] = 16'h0001; tm[1] = 3'b101; tr[1] = 16'hFFFF; tf[1] = 8'h80;
      ta[2] = 16'h1234; tb_[2] = 16'h1234; tm[2] = 3'b101; tr[2] = 16'h0000; tf[2] = 8'h03;
      ta[3] = 16'h0999; tb_[3] = 16'h0001; tm[3] = 3'b010; tr[3] = 16'h1000; tf[3] = 8'h00;
      ta[4] = 16'h9999; tb_[4] = 16'h0001; tm[4] = 3'b010; tr[4] = 16'h0000; tf[4] = 8'h03;
      ta[5] = 16'h1000; tb_[5] = 16'h0001; tm[5] = 3'b111; tr[5] = 16'h0999; tf[5] = 8'h01;
      ta[6] = 16'h00FF; tb_[6] = 16'h0001; tm[6] = 3'b000; tr[6] = 16'h0100; tf[6] = 8'h00;
      ta[7] = 16'h0058; tb_[7] = 16'h0046; tm[7] = 3'b011; tr[7] = 16'h0105; tf[7] = 8'h00;
      for (int i = 0; i < 8; i++) begin
         drive_start(ta[i], tb_[i], tm[i][2], tm[i][1], tm[i][0], 1'b1, tr[i], tf[i]);
         wait_done(0, cyc, gaps);
         checks++;
         if (cyc != 4 || gaps != 0) begin
            failures++; $display("FAIL arith%0d_latency: cycles=%0d busy_gaps=%0d expected 4/0", i, cyc, gaps);
         end
         checks++;
         if (sb.size() == 0) begin
            failures++; $display("FAIL arith%0d_scoreboard: queue empty expected 1 entry", i);
         end else begin
            e = sb.pop_front();
            if (result !== e.r || flags !== e.f || busy !== 1'b0) begin
               failures++;
               $display("FAIL arith%0d_result: result=%h flags=%h busy=%b expected %h/%h/0",
                        i, result, flags, busy, e.r, e.f);
            end
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || result !== tr[i] || flags !== tf[i]) begin
            failures++;
            $display("FAIL arith%0d_hold: done=%b result=%h flags=%h expected 0/%h/%h",
                     i, done, result, flags, tr[i], tf[i]);
         end
      end
   endtask

   task automatic test_start_while_busy;
      int cyc, gaps;
      exp_t e;
      drive_start(16'h0999, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1000, 8'h00);
      @(negedge clk);
      drive_start(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      wait_done(2, cyc, gaps);
      checks++;
      if (cyc != 4 || gaps != 0) begin
         failures++; $display("FAIL ignore_latency: cycles=%0d busy_gaps=%0d expected 4/0", cyc, gaps);
      end
      checks++;
      if (sb.size() != 1) begin
         failures++; $display("FAIL ignore_scoreboard: queue size=%0d expected 1", sb.size());
      end else begin
         e = sb.pop_front();
         if (result !== e.r || flags !== e.f) begin
            failures++;
            $display("FAIL ignore_result: result=%h flags=%h expected %h/%h", result, flags, e.r, e.f);
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL ignore_no_restart: busy=%b done=%b expected 0/0", busy, done);
      end
   endtask

   task automatic test_back_to_back;
      int cyc, gaps;
      exp_t e;
      drive_start(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2345, 8'h00);
      wait_done(0, cyc, gaps);
      if (sb.size() != 0) e = sb.pop_front();
      checks++;
      if (cyc != 4 || result !== 16'h2345 || flags !== 8'h00) begin
         failures++;
         $display("FAIL b2b_first: cycles=%0d result=%h flags=%h expected 4/2345/00", cyc, result, flags);
      end
      drive_start(16'h5000, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b1, 16'h4999, 8'h01);
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL b2b_busy: busy=%b expected 1", busy);
      end
      wait_done(0, cyc, gaps);
      checks++;
      if (cyc != 4 || gaps != 0) begin
         failures++; $display("FAIL b2b_latency: cycles=%0d busy_gaps=%0d expected 4/0", cyc, gaps);
      end
      checks++;
      if (sb.size() == 0) begin
         failures++; $display("FAIL b2b_scoreboard: queue empty expected 1 entry");
      end else begin
         e = sb.pop_front();
         if (result !== e.r || flags !== e.f) begin
            failures++;
            $display("FAIL b2b_result: result=%h flags=%h expected %h/%h", result, flags, e.r, e.f);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_abort;
      int seen, cyc, gaps;
      exp_t e;
      drive_start(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h43);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      if (sb.size() != 0) e = sb.pop_back();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || flags !== 8'h00) begin
         failures++;
         $display("FAIL abort_state: busy=%b done=%b result=%h flags=%h expected 0/0/0000/00",
                  busy, done, result, flags);
      end
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++; $display("FAIL abort_no_done: active cycles=%0d expected 0", seen);
      end
      drive_start(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h43);
      wait_done(0, cyc, gaps);
      checks++;
      if (sb.size() == 0) begin
         failures++; $display("FAIL abort_recover_scoreboard: queue empty expected 1 entry");
      end else begin
         e = sb.pop_front();
         if (cyc != 4 || result !== e.r || flags !== e.f) begin
            failures++;
            $display("FAIL abort_recover: cycles=%0d result=%h flags=%h expected 4/%h/%h",
                     cyc, result, flags, e.r, e.f);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_with_start;
      int seen;
      reset = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b0; dec = 1'b0; cin = 1'b0;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      seen = 0;
      repeat (6) begin
         if (busy === 1'b1 || done === 1'b1) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0 || result !== 16'h0000) begin
         failures++;
         $display("FAIL reset_start: active cycles=%0d result=%h expected 0/0000", seen, result);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_start_while_busy();
      test_back_to_back();
      test_abort();
      test_reset_with_start();
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
